loopback_router: RTL

LOOPBACK_ROUTER -- requirements
Module: loopback_router

---
 rtl/loopback_router_pkg.sv | 14 +
 rtl/loopback_fifo.sv | 48 ++++
 rtl/loopback_router.sv | 104 ++++++++++
 3 files changed

// File: rtl/loopback_router_pkg.sv
// Shared types and constants for the loopback router.
// The optional LOOPBACK_ROUTER_STATS_EN build uses BYTE_CNT_W for its per-channel counters.
package loopback_router_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int   BYTE_CNT_W    = 16;
    localparam logic MODE_STRAIGHT = 1'b0;
    localparam logic MODE_ROTATE   = 1'b1;

endpackage

// File: rtl/loopback_fifo.sv
// First-word-fall-through byte FIFO for one router channel.
// The pointers carry one extra bit so that full and empty can be told apart.
module loopback_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible while not empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

    assign data_o  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/loopback_router.sv
// Per-channel byte loopback with straight or rotate routing, plus a drain FSM for mode changes.
// Define LOOPBACK_ROUTER_STATS_EN to get per-channel delivered-byte counters on byte_cnt_o.
//
//  state    | meaning
//  ST_RUN   | accepting host bytes, routing under mode_o
//  ST_DRAIN | mode change pending: intake stopped, FIFOs emptying under the old mode
module loopback_router
    import loopback_router_pkg::*;
#(
    parameter int CHANNELS   = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           mode_i,
    input  logic [8*CHANNELS-1:0]          out_data_i,
    input  logic [CHANNELS-1:0]            out_valid_i,
    output logic [CHANNELS-1:0]            out_ready_o,
    output logic [8*CHANNELS-1:0]          in_data_o,
    output logic [CHANNELS-1:0]            in_valid_o,
    input  logic [CHANNELS-1:0]            in_ready_i,
    output logic                           mode_o,
    output logic                           draining_o,
    output logic [BYTE_CNT_W*CHANNELS-1:0] byte_cnt_o
);

    state_t              r_state;
    logic                r_mode;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_hs;
    logic [7:0]          w_head [CHANNELS];
    logic                w_rotate;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_mode  <= MODE_STRAIGHT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mode_i != r_mode) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Takes the latest mode_i, so a request withdrawn mid-drain leaves mode unchanged.
                    if (&w_empty) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode_i;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign mode_o      = r_mode;
    assign draining_o  = (r_state == ST_DRAIN);
    assign w_rotate    = (r_mode == MODE_ROTATE);
    assign out_ready_o = ~w_full & {CHANNELS{r_state == ST_RUN}};
    assign w_push      = out_valid_i & out_ready_o;
    assign w_hs        = in_valid_o & in_ready_i;

    for (genvar j = 0; j < CHANNELS; j++) begin : g_chan
        localparam int DST_ROT = (j + 1) % CHANNELS;
        localparam int SRC_ROT = (j + CHANNELS - 1) % CHANNELS;

        loopback_fifo #(
            .WIDTH (8),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (w_push[j]),
            .data_i  (out_data_i[8*j +: 8]),
            .pop_i   (w_pop[j]),
            .data_o  (w_head[j]),
            .full_o  (w_full[j]),
            .empty_o (w_empty[j])
        );

        // Index j is both a source FIFO (for pop) and a destination in channel (for valid/data).
        assign w_pop[j]          = w_rotate ? w_hs[DST_ROT] : w_hs[j];
        assign in_valid_o[j]     = w_rotate ? !w_empty[SRC_ROT] : !w_empty[j];
        assign in_data_o[8*j +: 8] = w_rotate ? w_head[SRC_ROT] : w_head[j];
    end

`ifdef LOOPBACK_ROUTER_STATS_EN
    for (genvar k = 0; k < CHANNELS; k++) begin : g_stats
        logic [BYTE_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk_i) begin
            if (rst_i)        r_cnt <= '0;
            else if (w_hs[k]) r_cnt <= r_cnt + 1'b1;
        end

        assign byte_cnt_o[BYTE_CNT_W*k +: BYTE_CNT_W] = r_cnt;
    end
`else
    assign byte_cnt_o = '0;
`endif

endmodule
